// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and timing constants for the HD44780-style LCD
//                bus reader and writer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

   typedef enum logic [2:0] {
      RD_IDLE   = 3'd0,
      RD_SETUP  = 3'd1,
      RD_E_HIGH = 3'd2,
      RD_E_LOW  = 3'd3,
      RD_RESP   = 3'd4
   } rd_state_e;

   localparam logic LCD_RW_READ  = 1'b1;
   localparam logic LCD_RW_WRITE = 1'b0;
   localparam logic LCD_RS_CMD   = 1'b0;
   localparam logic LCD_RS_DATA  = 1'b1;

   localparam int LCD_BF_BIT = 7;

   localparam int LCD_TAS_CYC_DEF  = 3;
   localparam int LCD_TEH_CYC_DEF  = 25;
   localparam int LCD_TEL_CYC_DEF  = 25;
   localparam int LCD_POLL_MAX_DEF = 4096;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_status_reader_if.sv
// ============================================================================
//  Module      : lcd_status_reader_if
//  Description : Request/response handshake between a requester and the LCD
//                status reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lcd_status_reader_if;
   logic       req_valid;
   logic       req_rs;
   logic       req_poll;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_busy;
   logic [6:0] rsp_addr;
   logic       rsp_timeout;

   modport master (
      output req_valid, req_rs, req_poll,
      input  req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
   );

   modport slave (
      input  req_valid, req_rs, req_poll,
      output req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
   );
endinterface

`default_nettype wire

// File: rtl/lcd_phase_timer.sv
// ============================================================================
//  Module      : lcd_phase_timer
//  Description : Loadable down-counter; o_done is high while the count is 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_phase_timer #(
   parameter int WIDTH = 5
) (
   input  wire logic             CLK,
   input  wire logic             RESET_N,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   output logic                  o_done
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_status_reader.sv
// ============================================================================
//  Module      : lcd_status_reader
//  Description : RW=1 bus master for an HD44780-style LCD: BF/AC reads, data
//                RAM reads and BF polling. Optional macro LCD_READ_TIMEOUT_EN
//                bounds polling to POLL_MAX reads.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_status_reader
   import lcd_pkg::*;
#(
   parameter int TAS_CYC  = LCD_TAS_CYC_DEF,
   parameter int TEH_CYC  = LCD_TEH_CYC_DEF,
   parameter int TEL_CYC  = LCD_TEL_CYC_DEF,
   parameter int POLL_MAX = LCD_POLL_MAX_DEF
) (
   input  wire logic          CLK,
   input  wire logic          RESET_N,
   lcd_status_reader_if.slave bus,
   output logic               bus_own,
   output logic               LCD_ENABLE,
   output logic               LCD_RW,
   output logic               LCD_RS,
   input  wire logic [7:0]    LCD_DATA_IN
);

   localparam logic [2:0] c_st_idle   = RD_IDLE;
   localparam logic [2:0] c_st_setup  = RD_SETUP;
   localparam logic [2:0] c_st_e_high = RD_E_HIGH;
   localparam logic [2:0] c_st_e_low  = RD_E_LOW;
   localparam logic [2:0] c_st_resp   = RD_RESP;

   localparam int c_cnt_w = $clog2(max3(TAS_CYC, TEH_CYC, TEL_CYC) + 1);
   localparam logic [c_cnt_w-1:0] c_tas_ld = c_cnt_w'(TAS_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_teh_ld = c_cnt_w'(TEH_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_tel_ld = c_cnt_w'(TEL_CYC - 1);

   generate
      if (TAS_CYC < 1 || TEH_CYC < 1 || TEL_CYC < 1 || POLL_MAX < 1) begin : g_param_check
         $error("lcd_status_reader: TAS_CYC, TEH_CYC, TEL_CYC and POLL_MAX must be >= 1");
      end
   endgenerate

   logic [2:0]         r_state;
   logic [2:0]         w_next;
   logic               r_rs;
   logic               w_rs_next;
   logic               r_poll;
   logic [7:0]         r_sample;
   logic               w_load;
   logic [c_cnt_w-1:0] w_load_val;
   logic               w_done;
   logic               w_accept;
   logic               w_sample_en;
   logic               w_poll_busy;
   logic               w_timeout_hit;
   logic               w_own_next;

   logic               r_e;
   logic               r_rw;
   logic               r_rs_pin;
   logic               r_own;
   logic               r_rsp_valid;
   logic [7:0]         r_rsp_data;
   logic               r_rsp_busy;
   logic [6:0]         r_rsp_addr;

   lcd_phase_timer #(
      .WIDTH (c_cnt_w)
   ) u_phase_timer (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   // BF=1 at the end of a poll read: either re-poll or give up on timeout
   assign w_poll_busy = (r_state == c_st_e_low) && w_done && r_poll && r_sample[LCD_BF_BIT];

   always_comb begin
      w_next      = r_state;
      w_rs_next   = r_rs;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_accept    = 1'b0;
      w_sample_en = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (bus.req_valid) begin
               w_accept   = 1'b1;
               w_rs_next  = bus.req_poll ? LCD_RS_CMD : bus.req_rs;
               w_next     = c_st_setup;
               w_load     = 1'b1;
               w_load_val = c_tas_ld;
            end
         end
         c_st_setup: begin
            if (w_done) begin
               w_next     = c_st_e_high;
               w_load     = 1'b1;
               w_load_val = c_teh_ld;
            end
         end
         c_st_e_high: begin
            if (w_done) begin
               w_sample_en = 1'b1;
               w_next      = c_st_e_low;
               w_load      = 1'b1;
               w_load_val  = c_tel_ld;
            end
         end
         c_st_e_low: begin
            if (w_done) begin
               if (w_poll_busy && !w_timeout_hit) begin
                  w_next     = c_st_setup;
                  w_load     = 1'b1;
                  w_load_val = c_tas_ld;
               end else begin
                  w_next = c_st_resp;
               end
            end
         end
         c_st_resp: w_next = c_st_idle;
         default:   w_next = c_st_idle;
      endcase
   end

   assign w_own_next = (w_next == c_st_setup) || (w_next == c_st_e_high) ||
                       (w_next == c_st_e_low);

   // Pin outputs are registered from the next state so they never glitch
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= c_st_idle;
         r_rs        <= LCD_RS_CMD;
         r_poll      <= 1'b0;
         r_sample    <= '0;
         r_e         <= 1'b0;
         r_rw        <= LCD_RW_WRITE;
         r_rs_pin    <= LCD_RS_CMD;
         r_own       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_busy  <= 1'b0;
         r_rsp_addr  <= '0;
      end else begin
         r_state  <= w_next;
         r_rs     <= w_rs_next;
         r_e      <= (w_next == c_st_e_high);
         r_own    <= w_own_next;
         r_rw     <= w_own_next ? LCD_RW_READ : LCD_RW_WRITE;
         r_rs_pin <= w_own_next ? w_rs_next : LCD_RS_CMD;
         if (w_accept) begin
            r_poll <= bus.req_poll;
         end
         if (w_sample_en) begin
            r_sample <= LCD_DATA_IN;
         end
         r_rsp_valid <= (r_state == c_st_resp);
         if (r_state == c_st_resp) begin
            r_rsp_data <= r_sample;
            r_rsp_busy <= (r_rs == LCD_RS_CMD) && r_sample[LCD_BF_BIT];
            r_rsp_addr <= (r_rs == LCD_RS_CMD) ? r_sample[6:0] : 7'd0;
         end
      end
   end

`ifdef LCD_READ_TIMEOUT_EN
   localparam int c_poll_w = $clog2(POLL_MAX + 1);
   localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_MAX - 1);

   logic [c_poll_w-1:0] r_poll_cnt;
   logic                r_timeout_flag;
   logic                r_rsp_timeout;

   // r_poll_cnt holds the number of completed BF=1 reads before the current one
   assign w_timeout_hit = (r_poll_cnt == c_poll_last);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_poll_cnt     <= '0;
         r_timeout_flag <= 1'b0;
         r_rsp_timeout  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_poll_cnt     <= '0;
            r_timeout_flag <= 1'b0;
         end else if (w_poll_busy) begin
            if (w_timeout_hit) begin
               r_timeout_flag <= 1'b1;
            end else begin
               r_poll_cnt <= r_poll_cnt + 1'b1;
            end
         end
         if (r_state == c_st_resp) begin
            r_rsp_timeout <= r_timeout_flag;
         end
      end
   end

   assign bus.rsp_timeout = r_rsp_timeout;
`else
   assign w_timeout_hit   = 1'b0;
   assign bus.rsp_timeout = 1'b0;
`endif

   assign bus.req_ready = (r_state == c_st_idle);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_busy  = r_rsp_busy;
   assign bus.rsp_addr  = r_rsp_addr;
   assign bus_own       = r_own;
   assign LCD_ENABLE    = r_e;
   assign LCD_RW        = r_rw;
   assign LCD_RS        = r_rs_pin;

endmodule

`default_nettype wire

// File: tb/tb_lcd_status_reader.sv
// ============================================================================
//  Module      : tb_lcd_status_reader
//  Description : Self-checking bench for lcd_status_reader with an LCD read
//                model. Honors LCD_READ_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_status_reader;

   localparam int TAS      = 3;
   localparam int TEH      = 25;
   localparam int TEL      = 25;
   localparam int PER      = TAS + TEH + TEL;
   localparam int POLL_MAX = 4;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       bus_own, LCD_ENABLE, LCD_RW, LCD_RS;
   logic [7:0] LCD_DATA_IN = 8'h00;

   int total = 0;
   int bad   = 0;

   logic [7:0] lcd_q[$];

   always #5 CLK = ~CLK;

   lcd_status_reader_if bus ();

   lcd_status_reader #(
      .TAS_CYC  (TAS),
      .TEH_CYC  (TEH),
      .TEL_CYC  (TEL),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .bus         (bus.slave),
      .bus_own     (bus_own),
      .LCD_ENABLE  (LCD_ENABLE),
      .LCD_RW      (LCD_RW),
      .LCD_RS      (LCD_RS),
      .LCD_DATA_IN (LCD_DATA_IN)
   );

   // LCD answers read i with lcd_q[i]; the last entry repeats forever
   function automatic logic [7:0] lcd_value(input int i);
      if (i < lcd_q.size()) return lcd_q[i];
      return lcd_q[lcd_q.size() - 1];
   endfunction

   function automatic void model(input bit rs, input bit poll, output int nreads,
                                 output logic [7:0] d, output logic busy,
                                 output logic [6:0] addr, output logic tmo);
      logic [7:0] v;
      bit rs_eff;
      rs_eff = poll ? 1'b0 : rs;
      tmo    = 1'b0;
      nreads = 1;
      if (poll) begin
         nreads = 0;
         for (int i = 0; i < 1000; i++) begin
            v = lcd_value(i);
            nreads++;
            if (!v[7]) break;
`ifdef LCD_READ_TIMEOUT_EN
            if (nreads == POLL_MAX) begin
               tmo = 1'b1;
               break;
            end
`endif
         end
      end
      d    = lcd_value(nreads - 1);
      busy = !rs_eff && d[7];
      addr = rs_eff ? 7'd0 : d[6:0];
   endfunction

   task automatic run_txn(input bit rs, input bit poll, input string name);
      int n, k, pulses, hi_len, own_cnt;
      logic [7:0] ed;
      logic eb, et;
      logic [6:0] ea;
      bit got, prev_e, pin_err, len_err, rdy_err, rs_eff;
      model(rs, poll, n, ed, eb, ea, et);
      rs_eff = poll ? 1'b0 : rs;
      @(negedge CLK);
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_before: got %b want 1", name, bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_rs    = rs;
      bus.req_poll  = poll;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      k = 0; pulses = 0; hi_len = 0; own_cnt = 0;
      got = 0; prev_e = 0; pin_err = 0; len_err = 0; rdy_err = 0;
      while (!got && k <= 1 + n * PER + 20) begin
         if (bus.rsp_valid === 1'b1) begin
            got = 1;
         end else begin
            if (bus.req_ready !== 1'b0) rdy_err = 1;
            if (LCD_ENABLE === 1'b1 && !prev_e) begin
               LCD_DATA_IN = lcd_value(pulses);
               pulses++;
            end
            if (LCD_ENABLE === 1'b1) hi_len++;
            else if (prev_e) begin
               if (hi_len != TEH) len_err = 1;
               hi_len = 0;
            end
            prev_e = (LCD_ENABLE === 1'b1);
            if (bus_own === 1'b1) begin
               own_cnt++;
               if (LCD_RW !== 1'b1 || LCD_RS !== rs_eff) pin_err = 1;
            end
            @(posedge CLK); #1;
            k++;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s no_response: waited %0d cycles, want rsp at %0d", name, k, 1 + n * PER);
      end else begin
         total++;
         if (k != 1 + n * PER) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, k, 1 + n * PER); end
         total++;
         if (pulses != n) begin bad++; $display("FAIL %s e_pulses: got %0d want %0d", name, pulses, n); end
         total++;
         if (bus.rsp_data !== ed) begin bad++; $display("FAIL %s rsp_data: got %h want %h", name, bus.rsp_data, ed); end
         total++;
         if (bus.rsp_busy !== eb) begin bad++; $display("FAIL %s rsp_busy: got %b want %b", name, bus.rsp_busy, eb); end
         total++;
         if (bus.rsp_addr !== ea) begin bad++; $display("FAIL %s rsp_addr: got %h want %h", name, bus.rsp_addr, ea); end
         total++;
         if (bus.rsp_timeout !== et) begin bad++; $display("FAIL %s rsp_timeout: got %b want %b", name, bus.rsp_timeout, et); end
         total++;
         if (own_cnt != n * PER) begin bad++; $display("FAIL %s own_cycles: got %0d want %0d", name, own_cnt, n * PER); end
         total++;
         if (pin_err || len_err || rdy_err) begin
            bad++;
            $display("FAIL %s protocol: rw/rs_err=%b e_len_err=%b ready_err=%b want 0 0 0", name, pin_err, len_err, rdy_err);
         end
         @(posedge CLK); #1;
         total++;
         if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== ed || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s after_resp: valid=%b data=%h ready=%b want 0 %h 1", name, bus.rsp_valid, bus.rsp_data, bus.req_ready, ed);
         end
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      #12;
      total++;
      if (LCD_ENABLE !== 1'b0 || LCD_RW !== 1'b0 || LCD_RS !== 1'b0 || bus_own !== 1'b0) begin
         bad++;
         $display("FAIL reset_pins: e=%b rw=%b rs=%b own=%b want 0 0 0 0", LCD_ENABLE, LCD_RW, LCD_RS, bus_own);
      end
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_busy !== 1'b0 ||
          bus.rsp_addr !== 7'h00 || bus.rsp_timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_rsp: valid=%b data=%h busy=%b addr=%h tmo=%b want all 0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_busy, bus.rsp_addr, bus.rsp_timeout);
      end
      total++;
      if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic test_reset_mid_e_high();
      int waited, stray;
      lcd_q.delete(); lcd_q.push_back(8'h12);
      @(negedge CLK);
      bus.req_valid = 1'b1; bus.req_rs = 1'b0; bus.req_poll = 1'b0;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      waited = 0;
      while (LCD_ENABLE !== 1'b1 && waited < 20) begin
         @(posedge CLK); #1;
         waited++;
      end
      repeat (9) begin @(posedge CLK); #1; end
      total++;
      if (LCD_ENABLE !== 1'b1) begin bad++; $display("FAIL rstmid_e_high: got %b want 1", LCD_ENABLE); end
      #2 RESET_N = 1'b0;
      #1;
      total++;
      if (LCD_ENABLE !== 1'b0 || bus_own !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_async: e=%b own=%b valid=%b want 0 0 0", LCD_ENABLE, bus_own, bus.rsp_valid);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
      stray = 0;
      repeat (60) begin
         @(posedge CLK); #1;
         if (bus.rsp_valid !== 1'b0 || LCD_ENABLE !== 1'b0) stray++;
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL rstmid_stray: got %0d active cycles want 0", stray); end
   endtask

   task automatic test_single_reads();
      logic [7:0] v;
      lcd_q.delete(); lcd_q.push_back(8'h45);
      run_txn(1'b0, 1'b0, "status_45");
      lcd_q.delete(); lcd_q.push_back(8'h31);
      run_txn(1'b1, 1'b0, "data_31");
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom_range(0, 255));
         lcd_q.delete(); lcd_q.push_back(v);
         run_txn(1'($urandom_range(0, 1)), 1'b0, "rand_single");
      end
   endtask

   task automatic test_poll();
      int nb;
      lcd_q.delete();
      lcd_q.push_back(8'h80); lcd_q.push_back(8'h80); lcd_q.push_back(8'h80); lcd_q.push_back(8'h07);
      run_txn(1'b1, 1'b1, "poll_3busy");
      for (int i = 0; i < 3; i++) begin
         nb = $urandom_range(0, 3);
         lcd_q.delete();
         for (int j = 0; j < nb; j++) lcd_q.push_back(8'($urandom_range(0, 255)) | 8'h80);
         lcd_q.push_back(8'($urandom_range(0, 255)) & 8'h7F);
         run_txn(1'($urandom_range(0, 1)), 1'b1, "rand_poll");
      end
   endtask

   task automatic test_timeout();
      lcd_q.delete(); lcd_q.push_back(8'hFF);
`ifdef LCD_READ_TIMEOUT_EN
      run_txn(1'b0, 1'b1, "poll_timeout");
`else
      begin
         int pulses, seen;
         bit prev_e;
         @(negedge CLK);
         bus.req_valid = 1'b1; bus.req_rs = 1'b0; bus.req_poll = 1'b1;
         @(posedge CLK); #1;
         bus.req_valid = 1'b0;
         pulses = 0; seen = 0; prev_e = 0;
         repeat (101 * PER + 50) begin
            if (LCD_ENABLE === 1'b1 && !prev_e) begin
               LCD_DATA_IN = lcd_value(pulses);
               pulses++;
            end
            prev_e = (LCD_ENABLE === 1'b1);
            if (bus.rsp_valid === 1'b1) seen++;
            @(posedge CLK); #1;
         end
         total++;
         if (pulses <= 100) begin bad++; $display("FAIL poll_forever_pulses: got %0d want >100", pulses); end
         total++;
         if (seen != 0) begin bad++; $display("FAIL poll_forever_rsp: got %0d responses want 0", seen); end
         RESET_N = 1'b0;
         repeat (2) @(posedge CLK);
         @(negedge CLK);
         RESET_N = 1'b1;
      end
`endif
   endtask

   task automatic test_back_to_back();
      int rsp_at[$], rdy_at[$];
      int pulses, extra;
      bit prev_e, ok_rsp, ok_rdy;
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      lcd_q.delete(); lcd_q.push_back(v);
      LCD_DATA_IN = v;
      @(negedge CLK);
      bus.req_valid = 1'b1; bus.req_rs = 1'b1; bus.req_poll = 1'b0;
      @(posedge CLK); #1;
      pulses = 0; prev_e = 0;
      for (int k = 0; k <= 3 * (PER + 2) - 1; k++) begin
         if (k > 0) begin @(posedge CLK); #1; end
         if (bus.rsp_valid === 1'b1) rsp_at.push_back(k);
         if (bus.req_ready === 1'b1) rdy_at.push_back(k);
         if (LCD_ENABLE === 1'b1 && !prev_e) pulses++;
         prev_e = (LCD_ENABLE === 1'b1);
      end
      bus.req_valid = 1'b0;
      extra = 0;
      repeat (60) begin
         @(posedge CLK); #1;
         if (bus.rsp_valid === 1'b1 || (LCD_ENABLE === 1'b1 && !prev_e)) extra++;
         prev_e = (LCD_ENABLE === 1'b1);
      end
      // Each transaction spans PER+1 cycles to the response plus one IDLE cycle
      ok_rsp = (rsp_at.size() == 3);
      ok_rdy = (rdy_at.size() == 3);
      for (int i = 0; i < 3; i++) begin
         if (ok_rsp && rsp_at[i] != 1 + PER + i * (PER + 2)) ok_rsp = 0;
         if (ok_rdy && rdy_at[i] != 1 + PER + i * (PER + 2)) ok_rdy = 0;
      end
      total++;
      if (!ok_rsp) begin
         bad++;
         $display("FAIL b2b_rsp_cycles: got %0d responses (first at %0d) want 3 at %0d step %0d",
                  rsp_at.size(), (rsp_at.size() > 0) ? rsp_at[0] : -1, 1 + PER, PER + 2);
      end
      total++;
      if (!ok_rdy) begin
         bad++;
         $display("FAIL b2b_ready_cycles: got %0d ready cycles (first at %0d) want 3 at %0d step %0d",
                  rdy_at.size(), (rdy_at.size() > 0) ? rdy_at[0] : -1, 1 + PER, PER + 2);
      end
      total++;
      if (pulses != 3 || extra != 0) begin
         bad++;
         $display("FAIL b2b_pulses: got %0d pulses %0d extra want 3 0", pulses, extra);
      end
      total++;
      if (bus.rsp_data !== v) begin bad++; $display("FAIL b2b_data: got %h want %h", bus.rsp_data, v); end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_rs    = 1'b0;
      bus.req_poll  = 1'b0;
      test_reset();
      test_reset_mid_e_high();
      test_single_reads();
      test_poll();
      test_timeout();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
